// File: rtl/sa_skew_feeder.sv
// ============================================================================
// Module      : sa_skew_feeder
// Description : Buffers one tile of two-lane image columns and replays it
//               diagonally skewed (lane 1 one cycle behind lane 0), then
//               waits a drain interval and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_skew_feeder #(
    parameter int DATA_W       = 8,
    parameter int K_MAX        = 8,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic              in_last,
    output logic [DATA_W-1:0] img_out0,
    output logic [DATA_W-1:0] img_out1,
    output logic              feed_valid,
    output logic              busy,
    output logic              done
);

    localparam int c_CW    = $clog2(K_MAX + 1);
    localparam int c_IW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int c_FW    = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int c_DEPTH = 1 << c_IW;

    localparam logic [c_CW-1:0] c_KMAX_M1 = c_CW'(K_MAX - 1);
    localparam logic [c_FW-1:0] c_FLUSH   = c_FW'(FLUSH_CYCLES);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_FEED  = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    logic [1:0]        r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   r_t;
    logic [c_FW-1:0]   r_fcnt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_img0;
    logic [DATA_W-1:0] r_img1;
    logic              r_feed_valid;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] r_buf0 [c_DEPTH];
    logic [DATA_W-1:0] r_buf1 [c_DEPTH];

    logic              w_accept;
    logic [c_CW-1:0]   w_wr_idx;
    logic              w_last_beat;
    logic [c_IW-1:0]   w_wr_addr;
    logic [c_IW-1:0]   w_rd0;
    logic [c_IW-1:0]   w_rd1;

    // in_ready is only ever high in IDLE/LOAD, so it alone qualifies a beat.
    assign w_accept    = in_valid & r_in_ready;
    assign w_wr_idx    = (r_state == c_ST_IDLE) ? '0 : r_cnt;
    assign w_last_beat = in_last | (w_wr_idx == c_KMAX_M1);
    assign w_wr_addr   = c_IW'(w_wr_idx);
    assign w_rd0       = c_IW'(r_t);
    assign w_rd1       = c_IW'(r_t - 1'b1);

    // Tile storage carries no reset; only indices below K are ever read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf0[w_wr_addr] <= in_data0;
            r_buf1[w_wr_addr] <= in_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_t          <= '0;
            r_fcnt       <= '0;
            r_in_ready   <= 1'b1;
            r_img0       <= '0;
            r_img1       <= '0;
            r_feed_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_LOAD: begin
                    if (w_accept) begin
                        r_cnt  <= w_wr_idx + 1'b1;
                        r_busy <= 1'b1;
                        if (w_last_beat) begin
                            r_state    <= c_ST_FEED;
                            r_t        <= '0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= c_ST_LOAD;
                        end
                    end
                end
                c_ST_FEED: begin
                    // r_cnt holds K here; step t covers 0..K inclusive.
                    r_img0       <= (r_t < r_cnt) ? r_buf0[w_rd0] : '0;
                    r_img1       <= (r_t != '0)   ? r_buf1[w_rd1] : '0;
                    r_feed_valid <= 1'b1;
                    if (r_t == r_cnt) begin
                        r_state <= c_ST_FLUSH;
                        r_fcnt  <= '0;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                c_ST_FLUSH: begin
                    r_img0       <= '0;
                    r_img1       <= '0;
                    r_feed_valid <= 1'b0;
                    if (r_fcnt == c_FLUSH) begin
                        r_state    <= c_ST_IDLE;
                        r_cnt      <= '0;
                        r_t        <= '0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign img_out0   = r_img0;
    assign img_out1   = r_img1;
    assign feed_valid = r_feed_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire
